// File: rtl/pht_ctrl.sv
// pht_ctrl: pattern-history-table controller driving a single pat_tab port.
// Define PHT_GSHARE_EN for gshare indexing (PC XOR GHR); otherwise the index is bimodal.
module pht_ctrl #(
    parameter int IDX_W = 14,
    parameter int PC_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_req,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_req,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic [IDX_W-1:0] pt_addr,
    output logic             pt_wr_en,
    output logic [1:0]       pt_wr_data,
    input  logic [1:0]       pt_rd_data
);
    typedef enum logic [2:0] {IDLE, P_RD, P_RSP, U_RD, U_WR} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] addr_reg;
    logic             upd_taken_reg;
    logic             pred_valid_reg;
    logic             pred_taken_reg;
    logic [IDX_W-1:0] pred_idx_reg;
    logic [IDX_W-1:0] ghr;
    logic [IDX_W-1:0] pc_index;
    logic [1:0]       ctr_next;
    logic             accept_pred;
    logic             accept_upd;
    logic             unused_pc;

`ifdef PHT_GSHARE_EN
    logic [IDX_W-1:0] ghr_reg;

    // History shifts in the write cycle, so a later prediction sees the resolved outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_reg <= '0;
        end else if (state_reg == U_WR) begin
            ghr_reg <= {ghr_reg[IDX_W-2:0], upd_taken_reg};
        end
    end
    assign ghr = ghr_reg;
`else
    assign ghr = '0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_index
            assign pc_index[gi] = pred_pc[gi+2] ^ ghr[gi];
        end
    endgenerate

    // Only the word-aligned index bits of the PC take part in the hash.
    assign unused_pc = ^pred_pc;

    always_comb begin
        ctr_next = pt_rd_data;
        if (upd_taken_reg) begin
            ctr_next = (pt_rd_data == 2'b11) ? 2'b11 : pt_rd_data + 2'd1;
        end else begin
            ctr_next = (pt_rd_data == 2'b00) ? 2'b00 : pt_rd_data - 2'd1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pred_ready  = 1'b0;
        upd_ready   = 1'b0;
        pt_wr_en    = 1'b0;
        pt_wr_data  = 2'b00;
        accept_pred = 1'b0;
        accept_upd  = 1'b0;
        case (state_reg)
            IDLE: begin
                upd_ready  = 1'b1;
                pred_ready = !upd_req;
                if (upd_req) begin
                    accept_upd = 1'b1;
                    state_next = U_RD;
                end else if (pred_req) begin
                    accept_pred = 1'b1;
                    state_next  = P_RD;
                end
            end
            P_RD:  state_next = P_RSP;
            P_RSP: state_next = IDLE;
            U_RD:  state_next = U_WR;
            U_WR: begin
                // A reset landing in the write cycle must not corrupt the table.
                pt_wr_en   = !reset;
                pt_wr_data = ctr_next;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            upd_taken_reg  <= 1'b0;
            pred_valid_reg <= 1'b0;
            pred_taken_reg <= 1'b0;
            pred_idx_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            pred_valid_reg <= (state_reg == P_RSP);
            if (accept_upd) begin
                addr_reg      <= upd_idx;
                upd_taken_reg <= upd_taken;
            end else if (accept_pred) begin
                addr_reg <= pc_index;
            end
            if (state_reg == P_RSP) begin
                pred_taken_reg <= pt_rd_data[1];
                pred_idx_reg   <= addr_reg;
            end
        end
    end

    assign pt_addr    = addr_reg;
    assign pred_valid = pred_valid_reg;
    assign pred_taken = pred_taken_reg;
    assign pred_idx   = pred_idx_reg;
endmodule

// File: tb/tb_pht_ctrl.sv
// tb_pht_ctrl: self-checking bench for pht_ctrl with a behavioural pat_tab and counter-table model.
// Honours PHT_GSHARE_EN the same way the design does.
module tb_pht_ctrl;
    localparam int IDX_W = 14;
    localparam int PC_W  = 16;
    localparam int DEPTH = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             pred_req;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_ready;
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_req;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_ready;
    logic [IDX_W-1:0] pt_addr;
    logic             pt_wr_en;
    logic [1:0]       pt_wr_data;
    logic [1:0]       pt_rd_data;

    int checks = 0;
    int failures = 0;

    logic [1:0]       mem [DEPTH];
    int               model_ctr [DEPTH];
    logic [IDX_W-1:0] model_ghr;

    always #5 clk = ~clk;

    pht_ctrl #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .pred_req(pred_req), .pred_pc(pred_pc), .pred_ready(pred_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
        .upd_req(upd_req), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .pt_addr(pt_addr), .pt_wr_en(pt_wr_en), .pt_wr_data(pt_wr_data), .pt_rd_data(pt_rd_data)
    );

    // Behavioural pat_tab: registered read, posedge write, reset clears.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
            pt_rd_data <= 2'b00;
        end else begin
            pt_rd_data <= mem[pt_addr];
            if (pt_wr_en) mem[pt_addr] <= pt_wr_data;
        end
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_ctr[i] = 0;
        model_ghr = '0;
    endtask

    task automatic model_update(input logic [IDX_W-1:0] idx, input logic tk, output logic [1:0] nv);
        int c;
        c = model_ctr[idx];
        if (tk) c = (c < 3) ? c + 1 : 3;
        else    c = (c > 0) ? c - 1 : 0;
        model_ctr[idx] = c;
        model_ghr = {model_ghr[IDX_W-2:0], tk};
        nv = 2'(c);
    endtask

    function automatic logic [IDX_W-1:0] exp_index(input logic [PC_W-1:0] pc);
        logic [IDX_W-1:0] b;
        b = pc[IDX_W+1:2];
`ifdef PHT_GSHARE_EN
        return b ^ model_ghr;
`else
        return b;
`endif
    endfunction

    function automatic logic [PC_W-1:0] pc_for_index(input logic [IDX_W-1:0] idx);
`ifdef PHT_GSHARE_EN
        return PC_W'({idx ^ model_ghr, 2'b00});
`else
        return PC_W'({idx, 2'b00});
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1; pred_req = 1'b0; upd_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Called and returns at a negedge; lat counts negedges from acceptance to pred_valid.
    task automatic issue_pred(input logic [PC_W-1:0] pc, output logic tk,
                              output logic [IDX_W-1:0] ix, output int lat);
        int n;
        n = 0;
        pred_pc = pc; pred_req = 1'b1;
        while (!pred_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        pred_req = 1'b0; lat = 1;
        while (!pred_valid && lat < 10) begin @(negedge clk); lat++; end
        tk = pred_taken; ix = pred_idx;
    endtask

    // Returns at the negedge inside the write cycle; lat counts negedges to pt_wr_en.
    task automatic issue_upd(input logic [IDX_W-1:0] idx, input logic tk, output logic [1:0] wd,
                             output int lat, output logic [IDX_W-1:0] addr_rd);
        int n;
        n = 0;
        upd_idx = idx; upd_taken = tk; upd_req = 1'b1;
        while (!upd_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        upd_req = 1'b0; lat = 1; addr_rd = pt_addr;
        while (!pt_wr_en && lat < 10) begin @(negedge clk); lat++; end
        wd = pt_wr_data;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 8;
        if (pred_ready !== 1'b1) begin failures++; $display("FAIL rst_pred_ready got=%b exp=1", pred_ready); end
        if (upd_ready !== 1'b1) begin failures++; $display("FAIL rst_upd_ready got=%b exp=1", upd_ready); end
        if (pred_valid !== 1'b0) begin failures++; $display("FAIL rst_pred_valid got=%b exp=0", pred_valid); end
        if (pred_taken !== 1'b0) begin failures++; $display("FAIL rst_pred_taken got=%b exp=0", pred_taken); end
        if (pred_idx !== '0) begin failures++; $display("FAIL rst_pred_idx got=%h exp=0", pred_idx); end
        if (pt_addr !== '0) begin failures++; $display("FAIL rst_pt_addr got=%h exp=0", pt_addr); end
        if (pt_wr_en !== 1'b0) begin failures++; $display("FAIL rst_pt_wr_en got=%b exp=0", pt_wr_en); end
        if (pt_wr_data !== 2'b00) begin failures++; $display("FAIL rst_pt_wr_data got=%b exp=00", pt_wr_data); end
    endtask

    task automatic test_predict_basic();
        logic tk; logic [IDX_W-1:0] ix; int lat;
        issue_pred(16'h0010, tk, ix, lat);
        $display("txn pred pc=0010 idx=%h taken=%b lat=%0d", ix, tk, lat);
        checks += 4;
        if (lat !== 3) begin failures++; $display("FAIL pred_latency got=%0d exp=3", lat); end
        if (tk !== 1'b0) begin failures++; $display("FAIL pred_taken_init got=%b exp=0", tk); end
        if (ix !== 14'h0004) begin failures++; $display("FAIL pred_idx_init got=%h exp=0004", ix); end
        @(negedge clk);
        if (pred_valid !== 1'b0) begin failures++; $display("FAIL pred_valid_pulse got=%b exp=0", pred_valid); end
    endtask

    task automatic test_saturate_up();
        logic [1:0] wd, mv; int lat; logic [IDX_W-1:0] ad;
        logic [1:0] exp_seq [4];
        exp_seq = '{2'b01, 2'b10, 2'b11, 2'b11};
        for (int k = 0; k < 4; k++) begin
            issue_upd(14'h0004, 1'b1, wd, lat, ad);
            model_update(14'h0004, 1'b1, mv);
            $display("txn upd idx=0004 taken=1 wdata=%b lat=%0d", wd, lat);
            checks += 3;
            if (wd !== exp_seq[k]) begin failures++; $display("FAIL sat_up_wdata[%0d] got=%b exp=%b", k, wd, exp_seq[k]); end
            if (lat !== 2) begin failures++; $display("FAIL upd_latency got=%0d exp=2", lat); end
            if (ad !== 14'h0004) begin failures++; $display("FAIL upd_rd_addr got=%h exp=0004", ad); end
        end
    endtask

    task automatic test_no_underflow();
        logic [1:0] wd, mv; int lat; logic [IDX_W-1:0] ad;
        issue_upd(14'h0005, 1'b0, wd, lat, ad);
        model_update(14'h0005, 1'b0, mv);
        $display("txn upd idx=0005 taken=0 wdata=%b lat=%0d", wd, lat);
        checks++;
        if (wd !== 2'b00) begin failures++; $display("FAIL no_underflow got=%b exp=00", wd); end
    endtask

    task automatic test_priority();
        logic [1:0] wd, mv; int lat; logic [IDX_W-1:0] ad, ix; logic tk;
        logic [PC_W-1:0] pc;
        issue_upd(14'h0009, 1'b1, wd, lat, ad);
        model_update(14'h0009, 1'b1, mv);
        @(negedge clk);
        model_update(14'h0009, 1'b1, mv);
        pc = pc_for_index(14'h0009);
        upd_idx = 14'h0009; upd_taken = 1'b1; upd_req = 1'b1;
        pred_pc = pc; pred_req = 1'b1;
        #1;
        checks += 6;
        if (pred_ready !== 1'b0) begin failures++; $display("FAIL prio_pred_ready got=%b exp=0", pred_ready); end
        if (upd_ready !== 1'b1) begin failures++; $display("FAIL prio_upd_ready got=%b exp=1", upd_ready); end
        @(posedge clk);
        @(negedge clk);
        upd_req = 1'b0; lat = 1;
        while (!pt_wr_en && lat < 10) begin @(negedge clk); lat++; end
        wd = pt_wr_data;
        $display("txn upd idx=0009 taken=1 wdata=%b (concurrent pred)", wd);
        if (wd !== mv) begin failures++; $display("FAIL prio_wdata got=%b exp=%b", wd, mv); end
        issue_pred(pc, tk, ix, lat);
        $display("txn pred pc=%h idx=%h taken=%b lat=%0d", pc, ix, tk, lat);
        if (ix !== 14'h0009) begin failures++; $display("FAIL prio_pred_idx got=%h exp=0009", ix); end
        if (tk !== 1'b1) begin failures++; $display("FAIL prio_pred_taken got=%b exp=1", tk); end
        if (lat !== 3) begin failures++; $display("FAIL prio_pred_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_gshare_index();
        logic [1:0] wd, mv; int lat; logic [IDX_W-1:0] ad, ix, exp_ix; logic tk;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            issue_upd(14'h0100, 1'b1, wd, lat, ad);
            model_update(14'h0100, 1'b1, mv);
        end
`ifdef PHT_GSHARE_EN
        exp_ix = 14'h0007;
`else
        exp_ix = 14'h0004;
`endif
        issue_pred(16'h0010, tk, ix, lat);
        $display("txn pred pc=0010 idx=%h taken=%b lat=%0d", ix, tk, lat);
        checks += 2;
        if (ix !== exp_ix) begin failures++; $display("FAIL ghr_index got=%h exp=%h", ix, exp_ix); end
        if (tk !== (model_ctr[exp_ix] >= 2)) begin failures++; $display("FAIL ghr_taken got=%b exp=%0d", tk, model_ctr[exp_ix] >= 2); end
    endtask

    task automatic test_random();
        logic [1:0] wd, mv; int lat; logic [IDX_W-1:0] ad, ix, exp_ix, last_idx, uidx;
        logic tk, exp_tk, utk; logic [PC_W-1:0] pc;
        last_idx = '0;
        for (int n = 0; n < 120; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                pc = PC_W'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
                exp_ix = exp_index(pc);
                exp_tk = (model_ctr[exp_ix] >= 2);
                issue_pred(pc, tk, ix, lat);
                last_idx = ix;
                $display("txn pred pc=%h idx=%h taken=%b lat=%0d", pc, ix, tk, lat);
                checks += 3;
                if (ix !== exp_ix) begin failures++; $display("FAIL rnd_pred_idx got=%h exp=%h", ix, exp_ix); end
                if (tk !== exp_tk) begin failures++; $display("FAIL rnd_pred_taken got=%b exp=%b", tk, exp_tk); end
                if (lat !== 3) begin failures++; $display("FAIL rnd_pred_latency got=%0d exp=3", lat); end
            end else begin
                uidx = ($urandom_range(0, 1) == 1) ? last_idx : IDX_W'($urandom_range(0, 31));
                utk = 1'($urandom_range(0, 1));
                issue_upd(uidx, utk, wd, lat, ad);
                model_update(uidx, utk, mv);
                $display("txn upd idx=%h taken=%b wdata=%b lat=%0d", uidx, utk, wd, lat);
                checks += 2;
                if (wd !== mv) begin failures++; $display("FAIL rnd_upd_wdata got=%b exp=%b", wd, mv); end
                if (lat !== 2) begin failures++; $display("FAIL rnd_upd_latency got=%0d exp=2", lat); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic tk; logic [IDX_W-1:0] ix; int lat;
        // Reset in U_RD
        @(negedge clk);
        while (!upd_ready) @(negedge clk);
        upd_idx = 14'h0004; upd_taken = 1'b1; upd_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        upd_req = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (pt_wr_en !== 1'b0) begin failures++; $display("FAIL rst_urd_wr_en got=%b exp=0", pt_wr_en); end
        if (upd_ready !== 1'b1) begin failures++; $display("FAIL rst_urd_idle got=%b exp=1", upd_ready); end
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        if (pt_wr_en !== 1'b0) begin failures++; $display("FAIL rst_urd_wr_en_after got=%b exp=0", pt_wr_en); end
        issue_pred(16'h0010, tk, ix, lat);
        $display("txn pred pc=0010 idx=%h taken=%b lat=%0d (after reset)", ix, tk, lat);
        checks += 2;
        if (ix !== 14'h0004) begin failures++; $display("FAIL rst_ghr_cleared got=%h exp=0004", ix); end
        if (tk !== 1'b0) begin failures++; $display("FAIL rst_urd_taken got=%b exp=0", tk); end
        // Reset in U_WR
        @(negedge clk);
        upd_idx = 14'h0004; upd_taken = 1'b1; upd_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        upd_req = 1'b0;
        @(negedge clk);
        checks += 2;
        if (pt_wr_en !== 1'b1) begin failures++; $display("FAIL uwr_wr_en got=%b exp=1", pt_wr_en); end
        reset = 1'b1;
        #1;
        if (pt_wr_en !== 1'b0) begin failures++; $display("FAIL rst_uwr_wr_en got=%b exp=0", pt_wr_en); end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        // Reset in P_RSP
        @(negedge clk);
        pred_pc = 16'h0010; pred_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pred_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pred_valid !== 1'b0) begin failures++; $display("FAIL rst_prsp_valid got=%b exp=0", pred_valid); end
        reset = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; pred_req = 1'b0; pred_pc = '0;
        upd_req = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        test_reset();
        test_predict_basic();
        test_saturate_up();
        test_no_underflow();
        test_priority();
        test_gshare_index();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
